// File: rtl/wb_bus_arbiter_pkg.sv
// wb_bus_arbiter_pkg: top-level parameter defaults and arbiter state type
package wb_bus_arbiter_pkg;
   localparam int WB_N_MASTERS        = 4;
   localparam int WB_N_BITS_MASTER_ID = 2;
   localparam int WB_TIMEOUT_CYCLES   = 255;
   typedef enum logic [1:0] {IDLE, GRANTED, TIMEOUT_DRAIN} arb_state_t;
endpackage

// File: rtl/wb_bus_arbiter_rr_priority_encoder.sv
// rr_priority_encoder: first requester at or after ptr, scanning upward with wrap
module rr_priority_encoder
   import wb_bus_arbiter_pkg::*;
#(
   parameter int N = WB_N_MASTERS,
   parameter int W = WB_N_BITS_MASTER_ID
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] idx,
   output logic         valid
);
   always_comb begin
      idx   = '0;
      valid = |req;
      // descending scan so the smallest offset from ptr is written last; only indices < N are visited
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
      end
   end
endmodule

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: round-robin WISHBONE bus arbiter with per-cycle grant hold
// and a response watchdog that errors out the owner of a stalled bus cycle
module wb_bus_arbiter
   import wb_bus_arbiter_pkg::*;
#(
   parameter int N_MASTERS        = WB_N_MASTERS,
   parameter int N_BITS_MASTER_ID = WB_N_BITS_MASTER_ID,
   parameter int TIMEOUT_CYCLES   = WB_TIMEOUT_CYCLES,
   parameter int N_BITS_TIMEOUT   = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_MASTERS-1:0]        cyc_i,
   input  logic                        ACK_I,
   input  logic                        ERR_I,
   input  logic                        RTY_I,
   output logic [N_MASTERS-1:0]        gnt_o,
   output logic [N_BITS_MASTER_ID-1:0] owner_o,
   output logic                        bus_busy_o,
   output logic [N_MASTERS-1:0]        timeout_err_o
);
   arb_state_t                  state, state_n;
   logic [N_BITS_MASTER_ID-1:0] rr_ptr, rr_n, owner_n, win, next_ptr;
   logic [N_MASTERS-1:0]        gnt_n, err_n;
   logic [N_BITS_TIMEOUT-1:0]   wdog, wd_n;
   logic                        busy_n, win_valid, resp, own_cyc;

   rr_priority_encoder #(.N(N_MASTERS), .W(N_BITS_MASTER_ID)) u_enc (
      .req   (cyc_i),
      .ptr   (rr_ptr),
      .idx   (win),
      .valid (win_valid)
   );

   assign resp     = ACK_I | ERR_I | RTY_I;
   assign own_cyc  = cyc_i[owner_o];
   assign next_ptr = (owner_o == N_BITS_MASTER_ID'(N_MASTERS - 1)) ? '0 : owner_o + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         owner_o       <= '0;
         gnt_o         <= '0;
         timeout_err_o <= '0;
         bus_busy_o    <= 1'b0;
         wdog          <= '0;
      end else begin
         state         <= state_n;
         rr_ptr        <= rr_n;
         owner_o       <= owner_n;
         gnt_o         <= gnt_n;
         timeout_err_o <= err_n;
         bus_busy_o    <= busy_n;
         wdog          <= wd_n;
      end
   end

   always_comb begin
      state_n = state;
      rr_n    = rr_ptr;
      owner_n = owner_o;
      gnt_n   = gnt_o;
      err_n   = '0;
      busy_n  = bus_busy_o;
      wd_n    = wdog;
      case (state)
         IDLE: begin
            wd_n   = '0;
            gnt_n  = win_valid ? N_MASTERS'(1) << win : '0;
            busy_n = win_valid;
            if (win_valid) begin
               state_n = GRANTED;
               owner_n = win;
            end
         end
         GRANTED: begin
            // release takes priority over a watchdog expiry in the same cycle
            if (!own_cyc) begin
               state_n = IDLE;
               gnt_n   = '0;
               busy_n  = 1'b0;
               rr_n    = next_ptr;
               wd_n    = '0;
            end else if (resp) begin
               wd_n = '0;
            end else if (wdog == N_BITS_TIMEOUT'(TIMEOUT_CYCLES - 1)) begin
               state_n        = TIMEOUT_DRAIN;
               gnt_n          = '0;
               err_n[owner_o] = 1'b1;
               wd_n           = '0;
            end else begin
               wd_n = wdog + 1'b1;
            end
         end
         default: begin
            gnt_n = '0;
            if (!own_cyc) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               rr_n    = next_ptr;
            end
         end
      endcase
   end
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the arbitration rules
module tb_wb_bus_arbiter;
   localparam int N = 4;
   localparam int T = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] cyc_i = '0;
   logic         ACK_I = 1'b0, ERR_I = 1'b0, RTY_I = 1'b0;
   logic [N-1:0] gnt_o, timeout_err_o;
   logic [1:0]   owner_o;
   logic         bus_busy_o;

   int checks = 0;
   int failures = 0;

   wb_bus_arbiter #(
      .N_MASTERS(N), .N_BITS_MASTER_ID(2), .TIMEOUT_CYCLES(T), .N_BITS_TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst), .cyc_i(cyc_i), .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I),
      .gnt_o(gnt_o), .owner_o(owner_o), .bus_busy_o(bus_busy_o), .timeout_err_o(timeout_err_o)
   );

   always #5 clk = ~clk;

   // reference model: who owns the bus, whether it is draining, how long it has been silent
   bit m_valid = 0, m_active = 0, m_drain = 0, m_err = 0;
   int m_owner = 0, m_ptr = 0, m_silent = 0;

   always @(posedge clk) begin
      m_err = 0;
      if (rst) begin
         m_active = 0; m_drain = 0; m_owner = 0; m_ptr = 0; m_silent = 0;
      end else if (!m_active) begin
         for (int k = 0; k < N; k++) begin
            if (!m_active && cyc_i[(m_ptr + k) % N]) begin
               m_active = 1; m_owner = (m_ptr + k) % N; m_silent = 0;
            end
         end
      end else if (!cyc_i[m_owner]) begin
         m_active = 0; m_drain = 0; m_ptr = (m_owner + 1) % N;
      end else if (!m_drain) begin
         if (ACK_I || ERR_I || RTY_I) m_silent = 0;
         else if (m_silent == T - 1) begin
            m_drain = 1; m_err = 1;
         end else m_silent++;
      end
      m_valid = 1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         logic [N-1:0] e_gnt, e_err;
         e_gnt = (m_active && !m_drain) ? N'(1) << m_owner : '0;
         e_err = m_err ? N'(1) << m_owner : '0;
         checks++;
         if (gnt_o !== e_gnt || owner_o !== 2'(m_owner) || bus_busy_o !== m_active || timeout_err_o !== e_err) begin
            failures++;
            $display("FAIL model t=%0t gnt=%b/%b owner=%0d/%0d busy=%b/%b err=%b/%b (actual/required)",
                     $time, gnt_o, e_gnt, owner_o, m_owner, bus_busy_o, m_active, timeout_err_o, e_err);
         end
      end
   end

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(3);
      checks++;
      if (gnt_o !== '0 || owner_o !== '0 || bus_busy_o !== 1'b0 || timeout_err_o !== '0) begin
         failures++;
         $display("FAIL reset gnt=%b owner=%0d busy=%b err=%b required all zero", gnt_o, owner_o, bus_busy_o, timeout_err_o);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single;
      cyc_i = 4'b0100; ACK_I = 1'b1;
      tick();
      checks++;
      if (gnt_o !== 4'b0100 || owner_o !== 2'd2 || bus_busy_o !== 1'b1) begin
         failures++;
         $display("FAIL single_grant gnt=%b owner=%0d busy=%b required 0100/2/1", gnt_o, owner_o, bus_busy_o);
      end
      cyc_i = 4'b0000;
      tick();
      checks++;
      if (gnt_o !== 4'b0000 || bus_busy_o !== 1'b0) begin
         failures++;
         $display("FAIL single_release gnt=%b busy=%b required 0000/0", gnt_o, bus_busy_o);
      end
      cyc_i = 4'b1001;
      tick();
      checks++;
      if (gnt_o !== 4'b1000) begin
         failures++;
         $display("FAIL single_ptr gnt=%b required 1000", gnt_o);
      end
      cyc_i = '0;
      tick(2);
   endtask

   task automatic test_fairness;
      int order[5] = '{0, 1, 2, 3, 0};
      cyc_i = 4'b1111; ACK_I = 1'b1;
      foreach (order[i]) begin
         tick();
         checks++;
         if (gnt_o !== N'(1) << order[i] || owner_o !== 2'(order[i])) begin
            failures++;
            $display("FAIL fair_order[%0d] gnt=%b owner=%0d required owner %0d", i, gnt_o, owner_o, order[i]);
         end
         tick(2);
         cyc_i[order[i]] = 1'b0;
         tick();
         checks++;
         if (gnt_o !== '0) begin
            failures++;
            $display("FAIL fair_dead[%0d] gnt=%b required 0000", i, gnt_o);
         end
         cyc_i[order[i]] = 1'b1;
      end
      cyc_i = '0;
      tick(2);
   endtask

   task automatic test_no_preempt;
      cyc_i = 4'b0010; ACK_I = 1'b1;
      tick();
      cyc_i = 4'b0011;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (gnt_o !== 4'b0010) begin
            failures++;
            $display("FAIL no_preempt[%0d] gnt=%b required 0010", i, gnt_o);
         end
      end
      cyc_i = 4'b0001;
      tick(2);
      checks++;
      if (gnt_o !== 4'b0001) begin
         failures++;
         $display("FAIL preempt_handover gnt=%b required 0001", gnt_o);
      end
      cyc_i = '0;
      tick(2);
   endtask

   task automatic test_watchdog;
      cyc_i = 4'b1000; ACK_I = 1'b0;
      tick();
      for (int i = 1; i < T; i++) begin
         tick();
         checks++;
         if (gnt_o !== 4'b1000 || timeout_err_o !== '0) begin
            failures++;
            $display("FAIL wd_early[%0d] gnt=%b err=%b required 1000/0000", i, gnt_o, timeout_err_o);
         end
      end
      tick();
      checks++;
      if (timeout_err_o !== 4'b1000 || gnt_o !== '0 || bus_busy_o !== 1'b1) begin
         failures++;
         $display("FAIL wd_fire err=%b gnt=%b busy=%b required 1000/0000/1", timeout_err_o, gnt_o, bus_busy_o);
      end
      tick(2);
      checks++;
      if (timeout_err_o !== '0 || gnt_o !== '0 || bus_busy_o !== 1'b1) begin
         failures++;
         $display("FAIL wd_drain err=%b gnt=%b busy=%b required 0000/0000/1", timeout_err_o, gnt_o, bus_busy_o);
      end
      cyc_i = '0;
      tick();
      checks++;
      if (bus_busy_o !== 1'b0) begin
         failures++;
         $display("FAIL wd_release busy=%b required 0", bus_busy_o);
      end
      cyc_i = 4'b1000;
      tick();
      for (int i = 0; i < 12; i++) begin
         ACK_I = (i % 3 == 2);
         tick();
         checks++;
         if (timeout_err_o !== '0 || gnt_o !== 4'b1000) begin
            failures++;
            $display("FAIL wd_acked[%0d] err=%b gnt=%b required 0000/1000", i, timeout_err_o, gnt_o);
         end
      end
      ACK_I = 1'b0; cyc_i = '0;
      tick(2);
   endtask

   task automatic test_race;
      cyc_i = 4'b1000;
      tick(T);
      cyc_i = '0;
      tick();
      checks++;
      if (timeout_err_o !== '0 || gnt_o !== '0 || bus_busy_o !== 1'b0) begin
         failures++;
         $display("FAIL race_drop err=%b gnt=%b busy=%b required 0000/0000/0", timeout_err_o, gnt_o, bus_busy_o);
      end
      cyc_i = 4'b1000;
      tick(T);
      ACK_I = 1'b1;
      tick();
      checks++;
      if (timeout_err_o !== '0 || gnt_o !== 4'b1000) begin
         failures++;
         $display("FAIL race_ack err=%b gnt=%b required 0000/1000", timeout_err_o, gnt_o);
      end
      ACK_I = 1'b0; cyc_i = '0;
      tick(2);
   endtask

   task automatic test_reset_mid;
      cyc_i = 4'b0100;
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if (gnt_o !== '0 || owner_o !== '0 || bus_busy_o !== 1'b0 || timeout_err_o !== '0) begin
         failures++;
         $display("FAIL reset_mid gnt=%b owner=%0d busy=%b err=%b required all zero", gnt_o, owner_o, bus_busy_o, timeout_err_o);
      end
      rst = 1'b0; cyc_i = 4'b0110;
      tick();
      checks++;
      if (gnt_o !== 4'b0010 || owner_o !== 2'd1) begin
         failures++;
         $display("FAIL reset_regrant gnt=%b owner=%0d required 0010/1", gnt_o, owner_o);
      end
      cyc_i = '0;
      tick(2);
   endtask

   task automatic test_random;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < N; b++) if ($urandom_range(0, 4) == 0) cyc_i[b] = ~cyc_i[b];
         ACK_I = ($urandom_range(0, 3) == 0);
         ERR_I = ($urandom_range(0, 15) == 0);
         RTY_I = ($urandom_range(0, 15) == 0);
         rst   = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0; cyc_i = '0; ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0;
      tick(3);
   endtask

   initial begin
      test_reset;
      test_single;
      test_fairness;
      test_no_preempt;
      test_watchdog;
      test_race;
      test_reset_mid;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
